sseg_capture: RTL and testbench

SSEG_CAPTURE -- requirements
Module: sseg_capture

---
 rtl/sseg_pkg.sv | 44 ++++
 rtl/sseg_decode.sv | 24 ++
 rtl/sseg_capture.sv | 157 +++++++++++++++
 tb/tb_sseg_capture.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: items shared by the seven-segment capture block and the display driver.
//   SEG_CODE    : active-low segment pattern (bit6=A .. bit0=G) for each hex digit
//   POS_ANODE   : active-low anode strobe for each digit position 0..3
//   ANODE_BLANK : all anodes off
//   state_t     : capture filter states
package sseg_pkg;

    localparam int unsigned NUM_POS = 4;

    // Entry n is the pattern for hex digit n (packed, so index 0 is the rightmost element).
    localparam logic [15:0][6:0] SEG_CODE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    localparam logic [NUM_POS-1:0][3:0] POS_ANODE = {
        4'b0111,  // position 3
        4'b1011,  // position 2
        4'b1101,  // position 1
        4'b1110   // position 0
    };

    localparam logic [3:0] ANODE_BLANK = 4'b1111;

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/sseg_decode.sv
// sseg_decode: combinational segment-pattern to hex-nibble decoder.
//   cathode : active-low segment pattern (bit6=A .. bit0=G)
//   legal   : pattern matches one of the 16 hex digit codes
//   nibble  : decoded digit value (0 when not legal)
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [6:0] cathode,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (cathode == SEG_CODE[i[3:0]]) begin
                legal  = 1'b1;
                nibble = i[3:0];
            end
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// sseg_capture: recovers the 4-digit hex value shown on a multiplexed,
// active-low seven-segment display by sampling its anode/cathode lines.
//   clk, rst_n : system clock, asynchronous active-low reset
//   anode      : active-low digit strobe (1110 = position 0 .. 0111 = position 3)
//   cathode    : active-low segments, bit6=A .. bit0=G
//   value      : last complete frame, position n at bits [4n+3:4n]
//   valid      : one-cycle pulse when value updates
//   err        : one-cycle pulse when an accepted sample is illegal
// Optional: define SSEG_CAPTURE_SYNC_EN to pass anode/cathode through a
// two-flop synchronizer (adds 2 cycles of latency) for asynchronous sources.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anode,
    input  logic [6:0]  cathode,
    output logic [15:0] value,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 1);

    logic [10:0] sample;

`ifdef SSEG_CAPTURE_SYNC_EN
    logic [10:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {anode, cathode};
            sync2 <= sync1;
        end
    end

    always_comb sample = sync2;
`else
    always_comb sample = {anode, cathode};
`endif

    state_t          state, state_next;
    logic [10:0]     prev;
    logic [7:0]      cnt, cnt_next;
    logic            same, accept;

    logic [3:0]      s_anode;
    logic [6:0]      s_cathode;
    logic            blank, one_hot, legal;
    logic [1:0]      pos;
    logic [3:0]      nibble;

    logic [3:0][3:0] frame, frame_next;
    logic [3:0]      seen, seen_next;
    logic            write, bad, full;

    always_comb begin
        s_anode   = sample[10:7];
        s_cathode = sample[6:0];
        same      = (sample == prev);
    end

    // Stability filter. The edge that first sees a new sample counts as
    // sample 1 (counter 0), so acceptance happens on the edge at which the
    // counter would reach STABLE_CYCLES-1, i.e. after STABLE_CYCLES
    // identical samples.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            SETTLE: begin
                if (!same) begin
                    cnt_next = '0;
                end else if (cnt == ACC_CNT - 8'd1) begin
                    cnt_next   = ACC_CNT;
                    accept     = 1'b1;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (!same) begin
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = SETTLE;
            end
        endcase
    end

    always_comb begin
        blank   = (s_anode == ANODE_BLANK);
        one_hot = 1'b0;
        pos     = '0;
        for (int unsigned i = 0; i < NUM_POS; i++) begin
            if (s_anode == POS_ANODE[i[1:0]]) begin
                one_hot = 1'b1;
                pos     = i[1:0];
            end
        end
    end

    sseg_decode u_decode (
        .cathode (s_cathode),
        .legal   (legal),
        .nibble  (nibble)
    );

    // Frame completion is folded into the accepting edge so that valid
    // appears exactly one cycle after acceptance.
    always_comb begin
        write      = accept && one_hot && legal;
        bad        = accept && !blank && !(one_hot && legal);
        frame_next = frame;
        seen_next  = seen;
        if (write) begin
            frame_next[pos] = nibble;
            seen_next[pos]  = 1'b1;
        end
        full = write && (seen_next == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            prev  <= '1;
            cnt   <= '0;
            frame <= '0;
            seen  <= '0;
            value <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            prev  <= sample;
            cnt   <= cnt_next;
            frame <= frame_next;
            seen  <= full ? '0 : seen_next;
            if (full) begin
                value <= frame_next;
            end
            valid <= full;
            err   <= bad;
        end
    end

endmodule

// File: tb/tb_sseg_capture.sv
// tb_sseg_capture: scoreboard bench for sseg_capture with directed vectors.
// Stimulus pushes expected valid/err events (kind, value, cycle) into a
// queue; a monitor on the falling edge pops and compares each DUT pulse.
module tb_sseg_capture;

    localparam int unsigned STABLE = 4;
`ifdef SSEG_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic [15:0] value;
    logic        valid;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        is_err;
        logic [15:0] value;
        int          cycle;
    } exp_t;

    exp_t q[$];

    sseg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .anode   (anode),
        .cathode (cathode),
        .value   (value),
        .valid   (valid),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:  seg = 7'b0000001;
            1:  seg = 7'b1001111;
            2:  seg = 7'b0010010;
            3:  seg = 7'b0000110;
            4:  seg = 7'b1001100;
            5:  seg = 7'b0100100;
            6:  seg = 7'b0100000;
            7:  seg = 7'b0001111;
            8:  seg = 7'b0000000;
            9:  seg = 7'b0000100;
            10: seg = 7'b0001000;
            11: seg = 7'b1100000;
            12: seg = 7'b0110001;
            13: seg = 7'b1000010;
            14: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present {a,c} for n clock edges; optionally expect an err or valid
    // pulse visible STABLE (+LAT) edges after the sample is applied.
    task automatic drive(input logic [3:0] a, input logic [6:0] c, input int n,
                         input bit exp_err, input bit exp_valid, input logic [15:0] exp_val);
        exp_t e;
        anode   = a;
        cathode = c;
        e.cycle = cyc + int'(STABLE) + LAT;
        if (exp_err) begin
            e.is_err = 1'b1;
            e.value  = '0;
            q.push_back(e);
        end
        if (exp_valid) begin
            e.is_err = 1'b0;
            e.value  = exp_val;
            q.push_back(e);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        drive(4'b1111, 7'b1111111, n, 1'b0, 1'b0, 16'h0);
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid === 1'b1 || err === 1'b1)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%b err=%b value=%h at cycle %0d, expected no pulse",
                         valid, err, value, cyc);
            end else begin
                m = q.pop_front();
                check("pulse_kind", {30'd0, valid, err}, m.is_err ? 32'd1 : 32'd2);
                check("pulse_cycle", cyc, m.cycle);
                if (!m.is_err) check("frame_value", {16'd0, value}, {16'd0, m.value});
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        anode   = 4'b1111;
        cathode = 7'b1111111;
        #2;
        check("reset_value", {16'd0, value}, 32'h0);
        check("reset_valid", {31'd0, valid}, 32'h0);
        check("reset_err", {31'd0, err}, 32'h0);
        check("reset_seen", {28'd0, dut.seen}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        blank(4);

        // Scan 1234: digits 4,3,2,1 on positions 0..3.
        drive(4'b1110, seg(4), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b1101, seg(3), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b1011, seg(2), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b0111, seg(1), 8, 1'b0, 1'b1, 16'h1234);
        blank(8);
        check("scan_hold_value", {16'd0, value}, 32'h1234);
        check("scan_seen_clear", {28'd0, dut.seen}, 32'h0);

        // Glitch: pattern on position 0 changes every 2 cycles.
        for (int i = 0; i < 5; i++)
            drive(4'b1110, seg((i % 2) ? 8 : 0), 2, 1'b0, 1'b0, 16'h0);
        check("glitch_seen", {28'd0, dut.seen}, 32'h0);
        blank(8);
        check("glitch_seen_after", {28'd0, dut.seen}, 32'h0);

        // Illegal cathode on position 1.
        drive(4'b1101, 7'b1111111, 8, 1'b1, 1'b0, 16'h0);
        blank(8);
        check("illegal_seen", {28'd0, dut.seen}, 32'h0);
        check("illegal_value_hold", {16'd0, value}, 32'h1234);

        // Multiple anodes low, then all anodes off with a lit pattern.
        drive(4'b1100, seg(5), 8, 1'b1, 1'b0, 16'h0);
        drive(4'b1111, seg(3), 8, 1'b0, 1'b0, 16'h0);
        blank(8);
        check("multi_seen", {28'd0, dut.seen}, 32'h0);

        // Overwrite: position 2 shows 7 then C.
        drive(4'b1011, seg(7), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b1011, seg(12), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b1110, seg(0), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b1101, seg(0), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b0111, seg(0), 8, 1'b0, 1'b1, 16'h0C00);
        blank(8);
        check("overwrite_value", {16'd0, value}, 32'h0C00);

        // Reset mid-frame discards the partial frame.
        drive(4'b1110, seg(5), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b1101, seg(6), 8, 1'b0, 1'b0, 16'h0);
        drive(4'b1011, seg(7), 8, 1'b0, 1'b0, 16'h0);
        check("partial_seen", {28'd0, dut.seen}, 32'h7);
        anode   = 4'b1111;
        cathode = 7'b1111111;
        rst_n   = 1'b0;
        #1;
        check("async_reset_value", {16'd0, value}, 32'h0);
        check("async_reset_seen", {28'd0, dut.seen}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0111, seg(8), 8, 1'b0, 1'b0, 16'h0);
        blank(8);
        check("post_reset_value", {16'd0, value}, 32'h0);
        check("post_reset_seen", {28'd0, dut.seen}, 32'h8);

        repeat (10) @(posedge clk);
        #1;
        check("pending_events", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
